// File: rtl/jtgng_zxdos_vgactrl.sv
// rtl/jtgng_zxdos_vgactrl.sv - PS/2 keyboard receiver and video hotkey decoder for ZX-Dos
//
// Receives PS/2 frames, exposes each good scan code, and decodes Scroll Lock
// (scan-doubler toggle) and keypad minus (scanline level step) into vgactrl_en.
//
// Ports:
//   clk_sys     system clock
//   rst         asynchronous active-high reset
//   ps2_clk     raw keyboard clock line
//   ps2_data    raw keyboard data line
//   vgactrl_en  [0] scan-doubler toggle, [3:1] scanline level
//   scan_code   last good data byte
//   scan_valid  one-cycle strobe when scan_code updates
//   frame_err   one-cycle strobe on parity or stop-bit error
module jtgng_zxdos_vgactrl #(
  parameter int          FILT = 8,
  parameter logic [15:0] TOUT = 16'd6000
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] vgactrl_en,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam logic [3:0] FILT_M1 = 4'(FILT - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // index 0 = clock line, index 1 = data line
  logic [1:0] sync1, sync2;
  logic [1:0] filt;
  logic [3:0] fcnt [2];
  logic       clk_d;
  logic       fall;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par;
  logic [15:0] to_cnt;

  logic ext, brk, held_sl, held_kp;

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {ps2_data, ps2_clk};
      sync2 <= sync1;
    end
  end

  // Filtered level flips only after FILT consecutive samples disagree with it
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      filt    <= 2'b11;
      fcnt[0] <= 4'd0;
      fcnt[1] <= 4'd0;
      clk_d   <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= 4'd0;
        end else if (fcnt[i] == FILT_M1) begin
          filt[i] <= sync2[i];
          fcnt[i] <= 4'd0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
      clk_d <= filt[0];
    end
  end

  assign fall = clk_d & ~filt[0];

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      par        <= 1'b0;
      to_cnt     <= 16'd0;
      scan_code  <= 8'd0;
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      scan_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || fall) to_cnt <= 16'd0;
      else                       to_cnt <= to_cnt + 16'd1;

      if (state != IDLE && !fall && to_cnt >= TOUT) begin
        // stalled frame: drop it silently
        state <= IDLE;
      end else if (fall) begin
        case (state)
          IDLE: begin
            if (!filt[1]) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shreg   <= {filt[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= filt[1];
            state <= STOP;
          end
          STOP: begin
            if (filt[1] && (^{par, shreg})) begin
              scan_valid <= 1'b1;
              scan_code  <= shreg;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Hotkey decoder, fed by the registered strobes
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      vgactrl_en <= 4'd0;
      ext        <= 1'b0;
      brk        <= 1'b0;
      held_sl    <= 1'b0;
      held_kp    <= 1'b0;
    end else if (frame_err) begin
      // a lost break must not leave a key stuck
      ext     <= 1'b0;
      brk     <= 1'b0;
      held_sl <= 1'b0;
      held_kp <= 1'b0;
    end else if (scan_valid) begin
      case (scan_code)
        8'hE0: ext <= 1'b1;
        8'hF0: brk <= 1'b1;
        8'hE1: ;
        default: begin
          if (!ext && scan_code == 8'h7E) begin
            if (brk) begin
              held_sl <= 1'b0;
            end else if (!held_sl) begin
              held_sl       <= 1'b1;
              vgactrl_en[0] <= ~vgactrl_en[0];
            end
          end
          if (!ext && scan_code == 8'h7B) begin
            if (brk) begin
              held_kp <= 1'b0;
            end else if (!held_kp) begin
              held_kp         <= 1'b1;
              vgactrl_en[3:1] <= vgactrl_en[3:1] + 3'd1;
            end
          end
          ext <= 1'b0;
          brk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtgng_zxdos_vgactrl.sv
// tb/tb_jtgng_zxdos_vgactrl.sv - self-checking bench for jtgng_zxdos_vgactrl
module tb_jtgng_zxdos_vgactrl;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] vgactrl_en;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  jtgng_zxdos_vgactrl #(.FILT(8), .TOUT(16'd6000)) dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .vgactrl_en (vgactrl_en),
    .scan_code  (scan_code),
    .scan_valid (scan_valid),
    .frame_err  (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  int         n_valid = 0;
  int         n_err = 0;
  int         n_both = 0;
  int         n_long = 0;
  logic       prev_valid = 1'b0;
  logic       prev_err = 1'b0;
  logic       grab = 1'b0;
  logic [3:0] en_at_valid = 4'd0;
  logic [3:0] en_after = 4'd0;

  always @(negedge clk_sys) begin
    if (scan_valid && frame_err) n_both++;
    if ((scan_valid && prev_valid) || (frame_err && prev_err)) n_long++;
    if (grab) begin
      en_after = vgactrl_en;
      grab = 1'b0;
    end
    if (scan_valid) begin
      n_valid++;
      en_at_valid = vgactrl_en;
      grab = 1'b1;
    end
    if (frame_err) n_err++;
    prev_valid = scan_valid;
    prev_err = frame_err;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit(~(^code) ^ bad);
    send_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(40);
  endtask

  typedef struct {
    logic [7:0] code;
    logic       bad;
    logic [3:0] exp_en;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] code, input logic bad, input logic [3:0] en);
    vec_t v;
    v.code = code;
    v.bad = bad;
    v.exp_en = en;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [7:0] exp_code;
    int         v0, e0;

    // scroll lock toggle
    add(8'h7E, 0, 4'b0001); add(8'hF0, 0, 4'b0001); add(8'h7E, 0, 4'b0001);
    add(8'h7E, 0, 4'b0000);
    // keypad minus wrap
    for (int k = 1; k <= 8; k++) begin
      add(8'h7B, 0, {3'(k), 1'b0});
      add(8'hF0, 0, {3'(k), 1'b0});
      add(8'h7B, 0, {3'(k), 1'b0});
    end
    // typematic repeat
    for (int k = 0; k < 5; k++) add(8'h7B, 0, 4'b0010);
    add(8'hF0, 0, 4'b0010); add(8'h7B, 0, 4'b0010); add(8'h7B, 0, 4'b0100);
    // extended codes ignored; release scroll lock then press it
    add(8'hE0, 0, 4'b0100); add(8'h7E, 0, 4'b0100);
    add(8'hE0, 0, 4'b0100); add(8'hF0, 0, 4'b0100); add(8'h7E, 0, 4'b0100);
    add(8'hF0, 0, 4'b0100); add(8'h7E, 0, 4'b0100);
    add(8'h7E, 0, 4'b0101);
    // bad parity clears held flags and prefix flags
    add(8'h7E, 1, 4'b0101); add(8'h7E, 0, 4'b0100);
    add(8'hE0, 0, 4'b0100); add(8'h12, 1, 4'b0100); add(8'h7B, 0, 4'b0110);
    add(8'hE1, 0, 4'b0110);
    add(8'hF0, 0, 4'b0110); add(8'h7E, 0, 4'b0110);
    add(8'hF0, 0, 4'b0110); add(8'h7B, 0, 4'b0110);

    wait_cyc(5);
    chk("reset_en", 32'(vgactrl_en), 32'h0);
    chk("reset_code", 32'(scan_code), 32'h0);
    chk("reset_valid", 32'(scan_valid), 32'h0);
    chk("reset_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    wait_cyc(20);

    exp_code = 8'h00;
    foreach (vecs[i]) begin
      v0 = n_valid;
      e0 = n_err;
      send_frame(vecs[i].code, vecs[i].bad);
      if (!vecs[i].bad) exp_code = vecs[i].code;
      chk($sformatf("vec%0d_valid", i), 32'(n_valid - v0), vecs[i].bad ? 32'd0 : 32'd1);
      chk($sformatf("vec%0d_err", i), 32'(n_err - e0), vecs[i].bad ? 32'd1 : 32'd0);
      chk($sformatf("vec%0d_code", i), 32'(scan_code), 32'(exp_code));
      chk($sformatf("vec%0d_en", i), 32'(vgactrl_en), 32'(vecs[i].exp_en));
    end

    // action lands one cycle after the scan_valid strobe
    send_frame(8'h7E, 0);
    chk("lat_en_at_valid", 32'(en_at_valid), 32'b0110);
    chk("lat_en_after", 32'(en_after), 32'b0111);
    send_frame(8'hF0, 0);
    send_frame(8'h7E, 0);

    // 3-cycle clock glitch while data is low must not start a frame
    ps2_data = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(20);
    ps2_data = 1'b1;
    wait_cyc(20);
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h7E, 0);
    chk("glitch_valid", 32'(n_valid - v0), 32'd1);
    chk("glitch_err", 32'(n_err - e0), 32'd0);
    chk("glitch_code", 32'(scan_code), 32'h7E);
    chk("glitch_en", 32'(vgactrl_en), 32'b0110);
    send_frame(8'hF0, 0);
    send_frame(8'h7E, 0);

    // partial frame abandoned by timeout
    v0 = n_valid;
    e0 = n_err;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    ps2_data = 1'b1;
    wait_cyc(6100);
    send_frame(8'h7E, 0);
    chk("tout_valid", 32'(n_valid - v0), 32'd1);
    chk("tout_err", 32'(n_err - e0), 32'd0);
    chk("tout_code", 32'(scan_code), 32'h7E);
    chk("tout_en", 32'(vgactrl_en), 32'b0111);

    // asynchronous reset mid-frame
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk_sys);
    rst = 1'b1;
    #1;
    chk("rst_mid_en", 32'(vgactrl_en), 32'h0);
    chk("rst_mid_code", 32'(scan_code), 32'h0);
    chk("rst_mid_valid", 32'(scan_valid), 32'h0);
    chk("rst_mid_err", 32'(frame_err), 32'h0);
    ps2_data = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(20);
    v0 = n_valid;
    e0 = n_err;
    send_frame(8'h7E, 0);
    chk("post_rst_valid", 32'(n_valid - v0), 32'd1);
    chk("post_rst_err", 32'(n_err - e0), 32'd0);
    chk("post_rst_code", 32'(scan_code), 32'h7E);
    chk("post_rst_en", 32'(vgactrl_en), 32'b0001);

    chk("strobes_overlap", 32'(n_both), 32'd0);
    chk("strobes_long", 32'(n_long), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
